// File: rtl/muller_c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muller_c_pkg : shared constants for the C-element handshake sequencer     |
// | Macro MULLER_C_SYNC2_EN selects the synchronizer depth (SYNC_LAT).       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package muller_c_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_A_UP    = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_A_DN    = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RISE = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_FALL = 2'd3;

`ifdef MULLER_C_SYNC2_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

endpackage
`default_nettype wire

// File: rtl/muller_c_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muller_c_sync : brings the asynchronous C-element output into clock.      |
// | MULLER_C_SYNC2_EN defined -> two flops, otherwise one flop.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module muller_c_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

`ifdef MULLER_C_SYNC2_EN
  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/muller_c_handshake_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muller_c_handshake_seq : four-phase exerciser/checker for a C-element.   |
// | Synchronizer depth set by MULLER_C_SYNC2_EN (see muller_c_sync). Rev 1.0 |
// +--------------------------------------------------------------------------+
module muller_c_handshake_seq
  import muller_c_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int TMO_W  = 4,
  parameter int SKEW_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_cycles,
  input  logic [SKEW_W-1:0] skew,
  input  logic              c_in,
  output logic              c_a,
  output logic              c_b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

  logic              c_s;
  logic [2:0]        state;
  logic [CNT_W-1:0]  n_reg;
  logic [SKEW_W-1:0] skew_reg;
  logic [SKEW_W-1:0] skew_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              skew_last;
  logic              tmo_last;
  logic [CNT_W-1:0]  cnt_next;

  muller_c_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (c_in),
    .q     (c_s)
  );

  assign skew_last = (skew_cnt == skew_reg - 1'b1);
  assign tmo_last  = (tmo_cnt == TMO_LAST);
  assign cnt_next  = done_cnt + 1'b1;

  // Both counters fall back to zero on every transition; only the hold branches advance them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      n_reg    <= '0;
      skew_reg <= '0;
      skew_cnt <= '0;
      tmo_cnt  <= '0;
      c_a      <= 1'b0;
      c_b      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      done_cnt <= '0;
    end else begin
      done     <= 1'b0;
      skew_cnt <= '0;
      tmo_cnt  <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_reg    <= n_cycles;
            skew_reg <= skew;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            done_cnt <= '0;
            if (n_cycles == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              c_a  <= 1'b1;
              busy <= 1'b1;
              if (skew == '0) begin
                c_b   <= 1'b1;
                state <= ST_WAIT_HI;
              end else begin
                state <= ST_A_UP;
              end
            end
          end
        end
        ST_A_UP: begin
          if (c_s) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_RISE;
            busy     <= 1'b0;
            c_a      <= 1'b0;
            c_b      <= 1'b0;
          end else if (skew_last) begin
            c_b   <= 1'b1;
            state <= ST_WAIT_HI;
          end else begin
            skew_cnt <= skew_cnt + 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (c_s) begin
            c_a <= 1'b0;
            if (skew_reg == '0) begin
              c_b   <= 1'b0;
              state <= ST_WAIT_LO;
            end else begin
              state <= ST_A_DN;
            end
          end else if (tmo_last) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_TMO;
            busy     <= 1'b0;
            c_a      <= 1'b0;
            c_b      <= 1'b0;
          end else begin
            tmo_cnt <= (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
          end
        end
        ST_A_DN: begin
          if (!c_s) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_FALL;
            busy     <= 1'b0;
            c_a      <= 1'b0;
            c_b      <= 1'b0;
          end else if (skew_last) begin
            c_b   <= 1'b0;
            state <= ST_WAIT_LO;
          end else begin
            skew_cnt <= skew_cnt + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!c_s) begin
            done_cnt <= cnt_next;
            if (cnt_next == n_reg) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              c_a <= 1'b1;
              if (skew_reg == '0) begin
                c_b   <= 1'b1;
                state <= ST_WAIT_HI;
              end else begin
                state <= ST_A_UP;
              end
            end
          end else if (tmo_last) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_TMO;
            busy     <= 1'b0;
            c_a      <= 1'b0;
            c_b      <= 1'b0;
          end else begin
            tmo_cnt <= (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
